// File: rtl/sevenseg_scan_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_if
// Bundles the digit data, display controls and pin-level outputs of the
// multiplexed seven-segment driver.
//
//   digits_in  [4*DIGITS]  packed digits, digit i = digits_in[4i+3:4i]
//   load                   capture digits_in into the pending register
//   blank_lz               leading-zero suppression enable
//   blink_mask [DIGITS]    per-digit blink enable
//   dp_in      [DIGITS]    per-digit decimal point request
//   seg        [7]         segments {g,f,e,d,c,b,a} at pin polarity
//   dp                     decimal point of the active digit at pin polarity
//   an         [DIGITS]    one-hot digit enable at pin polarity
//   frame_done             one-cycle pulse at each frame wrap
//
// master: the timekeeping side that drives digits/controls.
// slave : the display driver.
// -----------------------------------------------------------------------------
interface sevenseg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_in;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink_mask;
    logic [DIGITS-1:0]   dp_in;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output digits_in, load, blank_lz, blink_mask, dp_in,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digits_in, load, blank_lz, blink_mask, dp_in,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
// Multiplexed multi-digit seven-segment display driver. Latches a packed
// vector of hex/BCD digits and time-multiplexes them onto one shared segment
// bus with one-hot digit enables. Updates are frame-aligned (no frame ever
// mixes two loads), with leading-zero blanking, per-digit blink, decimal
// points and an anti-ghost blank slot at the start of every digit slot.
//
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    sevenseg_scan_if.slave (digits, controls, seg/dp/an/frame_done)
//
// Parameters:
//   DIGITS     number of digits scanned (1..8)
//   PRESCALE   clocks per digit slot (>= 2)
//   BLINK_DIV  frames per blink half-period (>= 1)
//   ACTIVE_LOW 1 = seg, dp and an are inverted at the pins
// -----------------------------------------------------------------------------
module sevenseg_scan #(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int BLINK_DIV  = 64,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic           clk,
    input logic           reset,
    sevenseg_scan_if.slave bus
);

    localparam int DW    = 4 * DIGITS;
    localparam int PRE_W = (PRESCALE > 1)  ? $clog2(PRESCALE)  : 1;
    localparam int IDX_W = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
    localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_DIV - 1);

    // Pin-level idle values (everything dark).
    localparam logic [6:0]        SEG_IDLE = {7{ACTIVE_LOW}};
    localparam logic              DP_IDLE  = ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{ACTIVE_LOW}};

    // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Scan and blink timing state.
    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    logic [BC_W-1:0]  bcnt;
    logic             bphase;

    // Digit storage: disp_reg is what is on the glass, pend_reg is staged.
    logic [DW-1:0]    disp_reg;
    logic [DW-1:0]    pend_reg;
    logic             pend_valid;

    logic             slot_end;
    logic             frame_end;

    assign slot_end  = (pre == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre    <= '0;
            idx    <= '0;
            bcnt   <= '0;
            bphase <= 1'b0;
        end else begin
            if (slot_end) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            if (frame_end) begin
                if (bcnt == BC_LAST) begin
                    bcnt   <= '0;
                    bphase <= ~bphase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    // A load always lands in pend_reg; the transfer uses the value staged
    // before this edge, so a load on the boundary cycle waits a full frame.
    // A load on the boundary also wins over the pend_valid clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                disp_reg <= pend_reg;
            end
            if (bus.load) begin
                pend_reg   <= bus.digits_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // ---- stage p0: select active digit and decide blanking ----
    logic [3:0]        cur_digit_p0;
    logic              cur_blink_p0;
    logic              cur_dp_p0;
    logic              upper_zero_p0;
    logic [DIGITS-1:0] sel_p0;
    logic              gate_off_p0;
    logic              lz_off_p0;
    logic [6:0]        seg_p0;
    logic              dp_p0;
    logic [DIGITS-1:0] an_p0;

    always_comb begin
        cur_digit_p0  = '0;
        cur_blink_p0  = 1'b0;
        cur_dp_p0     = 1'b0;
        upper_zero_p0 = 1'b1;
        sel_p0        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_p0[i]     = 1'b1;
                cur_digit_p0  = disp_reg[4*i +: 4];
                cur_blink_p0  = bus.blink_mask[i];
                cur_dp_p0     = bus.dp_in[i];
                // Digit i and everything to its left are zero.
                upper_zero_p0 = ((disp_reg >> (4*i)) == '0);
            end
        end

        // Anti-ghost slot and blink kill the whole digit including dp.
        gate_off_p0 = (pre == '0) || (cur_blink_p0 && bphase);
        // Leading-zero blanking never applies to the rightmost digit.
        lz_off_p0   = bus.blank_lz && (idx != '0) && upper_zero_p0;

        seg_p0 = (gate_off_p0 || lz_off_p0) ? 7'h00 : seg_decode(cur_digit_p0);
        dp_p0  = gate_off_p0 ? 1'b0 : cur_dp_p0;
        // A suppressed leading zero keeps its enable when it carries a dp.
        an_p0  = (gate_off_p0 || (lz_off_p0 && !cur_dp_p0)) ? '0 : sel_p0;
    end

    // ---- stage p1: registered pin outputs ----
    logic [6:0]        seg_p1;
    logic              dp_p1;
    logic [DIGITS-1:0] an_p1;
    logic              frame_done_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_p1        <= SEG_IDLE;
            dp_p1         <= DP_IDLE;
            an_p1         <= AN_IDLE;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= seg_p0 ^ {7{ACTIVE_LOW}};
            dp_p1         <= dp_p0 ^ ACTIVE_LOW;
            an_p1         <= an_p0 ^ {DIGITS{ACTIVE_LOW}};
            frame_done_p1 <= frame_end;
        end
    end

    assign bus.seg        = seg_p1;
    assign bus.dp         = dp_p1;
    assign bus.an         = an_p1;
    assign bus.frame_done = frame_done_p1;

endmodule
